alu_bist: RTL and testbench
===========================

Name: alu_bist

Overview:
- Synthesizable built-in self-test controller for the 8-bit ALU (`Top`).
- Generates the exhaustive {sel,a,b} stimulus in hardware and compresses every ALU `out` into a MISR signature.
- Raises done/pass against a golden signature.
- Sits beside `Top`: drives its a/b/sel and observes out. This replaces file-based vector checking on silicon/FPGA.

Parameters:
- WIDTH, 8, ALU operand width; pattern space is 2^(2*WIDTH+3).
- LAT, 0, ALU pipeline latency in cycles (0 = combinational), range 0..3.
- SIG_W, 16, signature width; must be >= WIDTH.
- POLY, 16'h1021, MISR feedback polynomial.
- SEED, 16'hFFFF, signature value at reset and at each start.
- GOLDEN, 16'h0000, expected final signature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; begins a test run.
- alu_a  out  WIDTH  operand a to ALU.
- alu_b  out  WIDTH  operand b to ALU.
- alu_sel  out  3  opcode to ALU.
- alu_out  in  WIDTH  ALU result.
- busy  out  1  run in progress.
- done  out  1  run complete; held until next start.
- pass  out  1  valid when done; 1 iff signature==GOLDEN.
- signature  out  SIG_W  current MISR value.
- pat_count  out  2*WIDTH+4  number of responses absorbed.

Behaviour:
- Reset (rst=0, async): state IDLE; alu_a/alu_b/alu_sel=0; busy=0; done=0; pass=0; signature=SEED; pat_count=0; valid pipe cleared.
- Pattern counter cnt is 2*WIDTH+3 bits, all outputs registered:
  - alu_sel = cnt[2*WIDTH+2:2*WIDTH]
  - alu_a = cnt[2*WIDTH-1:WIDTH]
  - alu_b = cnt[WIDTH-1:0]
  - b changes fastest, sel slowest.
- States IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 at edge -> RUN; cnt=0; signature=SEED; pat_count=0; busy=1; done=0; pass=0.
  - RUN: each edge cnt+1 and issue-valid shifts into a LAT-deep delay line. Wrap at max: cnt holds at all-ones, issue stops -> DRAIN. With LAT=0, go directly to DONE once the last response is absorbed.
  - DRAIN: waits until the delay line is empty -> DONE.
  - DONE: busy=0; done=1; pass=(signature==GOLDEN); held stable. start=1 -> behaves as from IDLE (restart).
- Absorb rule:
  - At any edge where the delayed valid is 1, update the MISR and increment pat_count.
  - LAT=0: the response to the pattern presented in cycle k is absorbed at the end of cycle k.
- MISR update: sig_n = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended alu_out.
- Timing: with N = 2^(2*WIDTH+3), done rises exactly N+LAT edges after the start edge; pat_count = N at done.
- start while RUN/DRAIN is ignored; there is no abort.
- start coincident with rst low: reset wins.
- rst low mid-run: immediate clear to reset values; the partial signature is lost.
- alu_out is ignored when no delayed valid is present. X on alu_out outside the absorb window must not corrupt the signature.

Decomposition:
- Package alu_bist_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default POLY/SEED constants;
  - the pattern-width function 2*WIDTH+3.
- Sub-module alu_bist_misr (SIG_W, POLY, SEED): clears on start, has an enable input, and absorbs data. The FSM, counter and valid pipe stay in alu_bist.

Test Plan:
- Reset/idle: rst=0 then 1, no start for 20 cycles -> all outputs 0, signature=16'hFFFF, busy=0.
- WIDTH=2, LAT=0, bench behavioural ALU model, single start pulse:
  - {sel,a,b} steps 0..127 one per cycle; busy=1 for 128 cycles; done at edge 128; pat_count=128.
  - signature equals the bench MISR model; with GOLDEN set to that value, pass=1.
- Fault injection, WIDTH=2: flip alu_out[0] on pattern 37 -> signature differs from the fault-free run; done=1, pass=0.
- LAT=2 with a registered ALU model, WIDTH=2:
  - signature identical to the LAT=0 run; done at edge 130.
  - start pulsed at cycle 60 is ignored.
- Restart and reset, WIDTH=2:
  - start in DONE -> second run gives an identical signature.
  - rst=0 at pattern 50 -> outputs clear within the same cycle; a later start produces the correct final signature.
- WIDTH=8 full run against `Top`: 524288 patterns; done at edge 524288; signature matches the model computed from the M8 golden outputs; pass=1.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU built-in self-test controller.
package alu_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'hFFFF;

    // Width of the {sel,a,b} pattern counter for a given operand width.
    function automatic int pat_width(input int width);
        return 32'sd2 * width + 32'sd3;
    endfunction

endpackage

// File: rtl/alu_bist_misr.sv
// Multiple-input signature register: folds one data word per enabled cycle
// into a Galois-style LFSR signature; srst reloads the seed.
module alu_bist_misr
    import alu_bist_pkg::*;
#(
    parameter int              SIG_W = 16,
    parameter int              DW    = 8,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED = SIG_W'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             srst,
    input  logic             en,
    input  logic [DW-1:0]    data,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_nxt
);

    logic [SIG_W-1:0] sig_r;

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                   input logic [DW-1:0]    din);
        logic [SIG_W-1:0] fb_s;
        if (cur[SIG_W-1]) begin
            fb_s = POLY;
        end else begin
            fb_s = '0;
        end
        return (cur << 1'b1) ^ fb_s ^ SIG_W'(din);
    endfunction

    // Next signature; data is only looked at when enabled so idle X cannot leak in.
    always_comb begin
        sig_nxt = sig_r;
        if (en) begin
            sig_nxt = misr_step(sig_r, data);
        end else begin
            sig_nxt = sig_r;
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_r <= SEED;
        end else if (srst) begin
            sig_r <= SEED;
        end else begin
            sig_r <= sig_nxt;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/alu_bist.sv
// BIST controller for the ALU: walks every {sel,a,b} pattern, compresses the
// responses into a MISR and flags pass/fail against a golden signature.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter int               LAT    = 0,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
    parameter logic [SIG_W-1:0] GOLDEN = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_sel,
    input  logic [WIDTH-1:0]   alu_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [SIG_W-1:0]   signature,
    output logic [2*WIDTH+3:0] pat_count
);

    localparam int PW = pat_width(WIDTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] CNT_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] PC_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_e           state_r, state_s;
    logic [PW-1:0]    cnt_r;
    logic [CW-1:0]    pat_count_r;
    logic             busy_r, done_r, pass_r;
    logic             issue_s, absorb_s, rest_s, last_s, start_s;
    logic [SIG_W-1:0] sig_nxt_s;

    assign issue_s = (state_r == RUN);
    assign last_s  = (cnt_r == {PW{1'b1}});
    assign start_s = start && ((state_r == IDLE) || (state_r == DONE));

    // The delay line lines issue-valid up with the ALU's response latency.
    generate
        if (LAT == 0) begin : g_nopipe
            assign absorb_s = issue_s;
            assign rest_s   = 1'b0;
        end else begin : g_pipe
            logic [LAT-1:0] vpipe_r;

            // Valid delay line, cleared on reset and on each accepted start.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vpipe_r <= '0;
                end else if (start_s) begin
                    vpipe_r <= '0;
                end else begin
                    vpipe_r <= (vpipe_r << 1'b1) | LAT'(issue_s);
                end
            end

            assign absorb_s = vpipe_r[LAT-1];
            // Anything still in flight besides the response absorbed this edge.
            assign rest_s   = |(vpipe_r << 1'b1);
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = (LAT == 0) ? DONE : DRAIN;
                else        state_s = RUN;
            end
            DRAIN: begin
                if (!rest_s) state_s = DONE;
                else         state_s = DRAIN;
            end
            DONE: begin
                if (start) state_s = RUN;
                else       state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Pattern counter; holds at all-ones once the last pattern is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (start_s) begin
            cnt_r <= '0;
        end else if (issue_s && !last_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Absorbed-response counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_count_r <= '0;
        end else if (start_s) begin
            pat_count_r <= '0;
        end else if (absorb_s) begin
            pat_count_r <= pat_count_r + PC_ONE;
        end else begin
            pat_count_r <= pat_count_r;
        end
    end

    // Status flags; pass is judged on the signature produced by the final absorb.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else if (start_s) begin
            busy_r <= 1'b1;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else if ((state_s == DONE) && (state_r != DONE)) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= (sig_nxt_s == GOLDEN);
        end else begin
            busy_r <= busy_r;
            done_r <= done_r;
            pass_r <= pass_r;
        end
    end

    alu_bist_misr #(
        .SIG_W (SIG_W),
        .DW    (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk     (clk),
        .rst     (rst),
        .srst    (start_s),
        .en      (absorb_s),
        .data    (alu_out),
        .sig     (signature),
        .sig_nxt (sig_nxt_s)
    );

    assign alu_sel   = cnt_r[2*WIDTH+2:2*WIDTH];
    assign alu_a     = cnt_r[2*WIDTH-1:WIDTH];
    assign alu_b     = cnt_r[WIDTH-1:0];
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign pat_count = pat_count_r;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist at WIDTH=2: a combinational-ALU instance
// (LAT=0) and a registered-ALU instance (LAT=2), checked against a MISR model.
module tb_alu_bist;

    function automatic logic [1:0] alu_f(input logic [2:0] s, input logic [1:0] a,
                                         input logic [1:0] b);
        case (s)
            3'd0:    alu_f = a + b;
            3'd1:    alu_f = a - b;
            3'd2:    alu_f = a & b;
            3'd3:    alu_f = a | b;
            3'd4:    alu_f = a ^ b;
            3'd5:    alu_f = ~(a & b);
            3'd6:    alu_f = a << 1'b1;
            default: alu_f = a >> 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] misr_f(input logic [15:0] s, input logic [1:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, d};
    endfunction

    function automatic logic [15:0] gold_f(input int flip);
        logic [15:0] s;
        logic [1:0]  d;
        logic [6:0]  p;
        s = 16'hFFFF;
        for (int k = 0; k < 128; k++) begin
            p = k[6:0];
            d = alu_f(p[6:4], p[3:2], p[1:0]);
            if (k == flip) d[0] = ~d[0];
            s = misr_f(s, d);
        end
        return s;
    endfunction

    localparam logic [15:0] GOLD = gold_f(-1);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start0 = 1'b0, start2 = 1'b0;
    logic        fault_en = 1'b0;
    logic [1:0]  alu_a0, alu_b0, alu_out0, alu_a2, alu_b2, alu_out2, r1, r2;
    logic [2:0]  alu_sel0, alu_sel2;
    logic        busy0, done0, pass0, busy2, done2, pass2;
    logic [15:0] sig0, sig2;
    logic [7:0]  pc0, pc2;

    int          which = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] sig_ref;
    logic [23:0] sb[$];

    logic [6:0]  mon_pat;
    logic        mon_busy, mon_done, mon_pass;
    logic [15:0] mon_sig;
    logic [7:0]  mon_pc;

    always #5 clk = ~clk;

    alu_bist #(.WIDTH(2), .LAT(0), .SIG_W(16), .POLY(16'h1021), .SEED(16'hFFFF),
               .GOLDEN(GOLD)) u0 (
        .clk(clk), .rst(rst), .start(start0), .alu_a(alu_a0), .alu_b(alu_b0),
        .alu_sel(alu_sel0), .alu_out(alu_out0), .busy(busy0), .done(done0),
        .pass(pass0), .signature(sig0), .pat_count(pc0));

    alu_bist #(.WIDTH(2), .LAT(2), .SIG_W(16), .POLY(16'h1021), .SEED(16'hFFFF),
               .GOLDEN(GOLD)) u2 (
        .clk(clk), .rst(rst), .start(start2), .alu_a(alu_a2), .alu_b(alu_b2),
        .alu_sel(alu_sel2), .alu_out(alu_out2), .busy(busy2), .done(done2),
        .pass(pass2), .signature(sig2), .pat_count(pc2));

    // Combinational ALU with an optional single-bit fault on pattern 37.
    assign alu_out0 = alu_f(alu_sel0, alu_a0, alu_b0) ^
        ((fault_en && ({alu_sel0, alu_a0, alu_b0} == 7'd37)) ? 2'b01 : 2'b00);

    // Two-stage registered ALU.
    always_ff @(posedge clk) begin
        r1 <= alu_f(alu_sel2, alu_a2, alu_b2);
        r2 <= r1;
    end
    assign alu_out2 = r2;

    assign mon_pat  = (which == 2) ? {alu_sel2, alu_a2, alu_b2} : {alu_sel0, alu_a0, alu_b0};
    assign mon_busy = (which == 2) ? busy2 : busy0;
    assign mon_done = (which == 2) ? done2 : done0;
    assign mon_pass = (which == 2) ? pass2 : pass0;
    assign mon_sig  = (which == 2) ? sig2 : sig0;
    assign mon_pc   = (which == 2) ? pc2 : pc0;

    task automatic run(input int lat, input bit fault, input int ign_cyc, input int rst_cyc);
        logic [15:0] s;
        logic [1:0]  d;
        logic [6:0]  p;
        logic [23:0] e;
        int          seen, done_cyc, exp_done;
        exp_done = 128 + lat;
        which    = lat;
        fault_en = fault;
        sb.delete();
        s = 16'hFFFF;
        @(posedge clk);
        #1;
        if (lat == 0) start0 = 1'b1; else start2 = 1'b1;
        for (int k = 0; k < 128; k++) begin
            p = k[6:0];
            d = alu_f(p[6:4], p[3:2], p[1:0]);
            if (fault && k == 37) d[0] = ~d[0];
            s = misr_f(s, d);
            sb.push_back({{1'b0, p} + 8'd1, s});
        end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
        seen = 0;
        done_cyc = -1;
        for (int cyc = 0; cyc <= exp_done + 2; cyc++) begin
            @(negedge clk);
            start0 = 1'b0;
            start2 = 1'b0;
            if (cyc < 128) begin
                n_checks++;
                if (mon_pat !== cyc[6:0])
                    $display("FAIL pattern lat=%0d cyc=%0d got %0d want %0d", lat, cyc, mon_pat, cyc);
                else n_pass++;
            end
            n_checks++;
            if ({mon_busy, mon_done} !== {cyc < exp_done, cyc >= exp_done})
                $display("FAIL busy_done lat=%0d cyc=%0d got %b%b want %b%b", lat, cyc,
                         mon_busy, mon_done, cyc < exp_done, cyc >= exp_done);
            else n_pass++;
            if (mon_done && done_cyc < 0) done_cyc = cyc;
            if (mon_pc !== seen[7:0]) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL absorb_extra lat=%0d cyc=%0d got pc=%0d want no absorb", lat, cyc, mon_pc);
                end else begin
                    e = sb.pop_front();
                    if ({mon_pc, mon_sig} !== e)
                        $display("FAIL absorb lat=%0d cyc=%0d got pc=%0d sig=%h want pc=%0d sig=%h",
                                 lat, cyc, mon_pc, mon_sig, e[23:16], e[15:0]);
                    else n_pass++;
                end
                seen = int'(mon_pc);
            end
            if (cyc == ign_cyc) begin
                if (lat == 0) start0 = 1'b1; else start2 = 1'b1;
            end
            if (cyc == rst_cyc) begin
                #2 rst = 1'b0;
                #1;
                n_checks++;
                if ({mon_pat, mon_busy, mon_done, mon_pass, mon_pc, mon_sig} !== {18'd0, 16'hFFFF})
                    $display("FAIL midrun_reset got pat=%0d busy=%b done=%b pc=%0d sig=%h want 0,0,0,0,ffff",
                             mon_pat, mon_busy, mon_done, mon_pc, mon_sig);
                else n_pass++;
                @(posedge clk);
                #1 rst = 1'b1;
                return;
            end
        end
        n_checks++;
        if (done_cyc != exp_done)
            $display("FAIL done_edge lat=%0d got %0d want %0d", lat, done_cyc, exp_done);
        else n_pass++;
        n_checks++;
        if ({mon_pc, mon_sig, mon_pass} !== {8'd128, s, ~fault})
            $display("FAIL final lat=%0d got pc=%0d sig=%h pass=%b want pc=128 sig=%h pass=%b",
                     lat, mon_pc, mon_sig, mon_pass, s, ~fault);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL sb_drain lat=%0d got %0d left want 0", lat, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 start0 = 1'b0;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({alu_sel0, alu_a0, alu_b0, busy0, done0, pass0, pc0} !== 18'd0)
            $display("FAIL reset_u0 got %h want 0", {alu_sel0, alu_a0, alu_b0, busy0, done0, pass0, pc0});
        else n_pass++;
        n_checks++;
        if (sig0 !== 16'hFFFF) $display("FAIL reset_sig0 got %h want ffff", sig0);
        else n_pass++;
        n_checks++;
        if ({alu_sel2, alu_a2, alu_b2, busy2, done2, pass2, pc2} !== 18'd0)
            $display("FAIL reset_u2 got %h want 0", {alu_sel2, alu_a2, alu_b2, busy2, done2, pass2, pc2});
        else n_pass++;
        n_checks++;
        if (sig2 !== 16'hFFFF) $display("FAIL reset_sig2 got %h want ffff", sig2);
        else n_pass++;
    endtask

    task automatic test_lat0;
        run(0, 1'b0, -1, -1);
        sig_ref = mon_sig;
    endtask

    task automatic test_restart;
        run(0, 1'b0, -1, -1);
        n_checks++;
        if (mon_sig !== sig_ref) $display("FAIL restart_sig got %h want %h", mon_sig, sig_ref);
        else n_pass++;
    endtask

    task automatic test_fault;
        run(0, 1'b1, -1, -1);
        n_checks++;
        if (mon_sig === GOLD) $display("FAIL fault_sig got %h want not %h", mon_sig, GOLD);
        else n_pass++;
        fault_en = 1'b0;
    endtask

    task automatic test_lat2;
        run(2, 1'b0, 60, -1);
        n_checks++;
        if (mon_sig !== sig_ref) $display("FAIL lat2_sig got %h want %h", mon_sig, sig_ref);
        else n_pass++;
    endtask

    task automatic test_midrun_reset;
        run(0, 1'b0, -1, 50);
        run(0, 1'b0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_lat0();
        test_restart();
        test_fault();
        test_lat2();
        test_midrun_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
